pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Next-PC controller for the program counter register; feeds that register's next-value input each cycle.
- Sequences fetch addresses:
  - sequential increment
  - PC-relative branch
  - absolute jump
  - call and return through a small return-address stack (RAS)
  - halt/resume
- Handshakes with the fetch stage; accepts redirects from the execute stage.

Parameters:
- PC_W, 16, width of PC and all address/offset ports
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2)
- RESET_VEC, 16'h0000, PC value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_ready_i  in  1  fetch stage accepts pc_o this cycle
- fetch_valid_o  out  1  pc_o is a valid fetch address
- pc_o  out  PC_W  current fetch address; drives the PC register input
- br_taken_i  in  1  taken branch resolved this cycle
- br_off_i  in  PC_W  signed two's-complement branch offset
- jmp_i  in  1  absolute jump
- call_i  in  1  call: jump plus push of return address
- jmp_tgt_i  in  PC_W  target for jmp_i/call_i
- ret_i  in  1  return: pop RAS
- halt_i  in  1  request halt
- resume_i  in  1  leave halt
- halted_o  out  1  state is HALT
- ras_ovf_o  out  1  sticky: push while RAS full
- ras_unf_o  out  1  sticky: pop while RAS empty

Behaviour:
- Reset (async assert, rst_n=0):
  - pc_o=RESET_VEC, fetch_valid_o=0, halted_o=0
  - RAS count=0, ras_ovf_o=0, ras_unf_o=0
  - state=BOOT
- States:
  - BOOT: one cycle after reset release with fetch_valid_o=0, then RUN.
  - RUN: fetch_valid_o=1.
  - HALT: fetch_valid_o=0, halted_o=1, pc_o held. Redirects are still applied to pc_o and RAS. resume_i moves to RUN next cycle.
- Advance rule in RUN:
  - pc_o <= pc_o+1 only when fetch_valid_o && fetch_ready_i and no redirect.
  - Otherwise pc_o holds.
- Redirects are applied next cycle regardless of fetch_ready_i and override the increment.
- Redirect priority, highest first; lower-priority inputs in the same cycle are ignored:
  - ret_i: pc_o <= top of stack; pop.
  - call_i: pc_o <= jmp_tgt_i; push pc_o+1.
  - jmp_i: pc_o <= jmp_tgt_i.
  - br_taken_i: pc_o <= pc_o + sign-extended br_off_i.
- Arithmetic is modulo 2^PC_W; wrap-around is silent, so 16'hFFFF+1 = 16'h0000.
- RAS is a circular buffer with a count saturating at RAS_DEPTH:
  - Push when full: overwrite oldest entry, set ras_ovf_o.
  - Pop when empty: pc_o <= RESET_VEC, set ras_unf_o, count stays 0.
- halt_i in RUN: enter HALT next cycle. An increment in the same cycle still occurs if handshake completes.
- halt_i and resume_i together: halt wins.
- resume_i in RUN/BOOT: ignored.
- Reset mid-operation: all state cleared immediately; in-flight redirect discarded.

Optional Feature:
- Macro: PC_SEQ_PERF_EN
- Defined:
  - Adds outputs redirect_cnt_o[15:0] and fetch_cnt_o[15:0].
  - redirect_cnt_o increments on each applied redirect; fetch_cnt_o increments on each handshake.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined:
  - Ports and counters absent.
  - Behaviour otherwise identical.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state enum (BOOT, RUN, HALT)
  - redirect-kind enum (NONE, RET, CALL, JMP, BR)
  - PC_W default and RESET_VEC constant
- One sub-module: pc_ras, the circular return-address stack with push/pop/full/empty and overflow/underflow flags.

Test Plan:
- Reset release, fetch_ready_i=1 held → cycle1 fetch_valid_o=0, pc_o=0000; then 0000,0001,0002 on successive cycles.
- fetch_ready_i low 3 cycles at pc_o=0005 → pc_o holds 0005; raise → 0006.
- pc_o=0010, br_taken_i=1, br_off_i=FFFC → 000C.
- pc_o=FFFF with handshake → 0000.
- call_i with jmp_tgt_i=0200 at pc_o=0030 → 0200; later ret_i → 0031.
- Five calls with RAS_DEPTH=4 → ras_ovf_o=1; five rets → last gives RESET_VEC and ras_unf_o=1.
- ret_i and jmp_i in the same cycle → ret target taken.
- halt_i → halted_o=1, fetch_valid_o=0, pc_o frozen; resume_i → RUN next cycle.
- rst_n pulsed low mid-call → pc_o=0000, RAS empty, flags cleared asynchronously.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_sequencer slice.
package pc_seq_pkg;

  localparam int          PC_W_DEF      = 16;
  localparam logic [15:0] RESET_VEC_DEF = 16'h0000;
  localparam logic [15:0] PERF_MAX      = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

  typedef enum logic [2:0] {
    RD_NONE = 3'd0,
    RD_RET  = 3'd1,
    RD_CALL = 3'd2,
    RD_JMP  = 3'd3,
    RD_BR   = 3'd4
  } redirect_e;

  // Highest-priority redirect wins; anything below it in the same cycle is dropped.
  function automatic redirect_e pick_redirect(input logic ret, input logic call,
                                              input logic jmp, input logic br);
    redirect_e kind;
    if (ret) begin
      kind = RD_RET;
    end else if (call) begin
      kind = RD_CALL;
    end else if (jmp) begin
      kind = RD_JMP;
    end else if (br) begin
      kind = RD_BR;
    end else begin
      kind = RD_NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; the count saturates at DEPTH, a push when full
// overwrites the oldest entry. Overflow/underflow flags are sticky until reset.
module pc_ras #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         ovf_o,
  output logic         unf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [CNT_W-1:0] cnt_q;
  logic             full_s;
  logic             empty_s;
  logic             ovf_q;
  logic             unf_q;

  assign wr_ptr_s = top_q + PTR_W'(1'b1);
  assign full_s   = (cnt_q == FULL_CNT);
  assign empty_s  = (cnt_q == {CNT_W{1'b0}});
  assign top_o    = mem_q[top_q];
  assign empty_o  = empty_s;
  assign ovf_o    = ovf_q;
  assign unf_o    = unf_q;

  // Stack storage, pointer, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else if (push_i) begin
      mem_q[wr_ptr_s] <= push_data_i;
      top_q           <= wr_ptr_s;
      if (full_s) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1'b1);
      end
    end else if (pop_i) begin
      if (empty_s) begin
        unf_q <= 1'b1;
      end else begin
        top_q <= top_q - PTR_W'(1'b1);
        cnt_q <= cnt_q - CNT_W'(1'b1);
      end
    end else begin
      top_q <= top_q;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: increment, branch, jump, call/return via RAS, halt/resume.
// Define PC_SEQ_PERF_EN to add saturating redirect/fetch counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [PC_W-1:0] pc_o,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_off_i,
  input  logic            jmp_i,
  input  logic            call_i,
  input  logic [PC_W-1:0] jmp_tgt_i,
  input  logic            ret_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic            halted_o,
  output logic            ras_ovf_o,
  output logic            ras_unf_o
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [15:0]     redirect_cnt_o,
  output logic [15:0]     fetch_cnt_o
`endif
);

  seq_state_e      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            valid_q;
  logic            halted_q;

  redirect_e       rd_s;
  logic            hs_s;
  logic [PC_W-1:0] inc_s;
  logic [PC_W-1:0] ras_top_s;
  logic            ras_empty_s;
  logic            push_s;
  logic            pop_s;

  assign rd_s   = pick_redirect(ret_i, call_i, jmp_i, br_taken_i);
  assign hs_s   = valid_q & fetch_ready_i;
  assign inc_s  = pc_q + PC_W'(1'b1);
  assign push_s = (rd_s == RD_CALL);
  assign pop_s  = (rd_s == RD_RET);

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (inc_s),
    .top_o       (ras_top_s),
    .empty_o     (ras_empty_s),
    .ovf_o       (ras_ovf_o),
    .unf_o       (ras_unf_o)
  );

  // Next PC: redirects apply in every state; the increment needs a completed handshake.
  always_comb begin
    pc_d = pc_q;
    case (rd_s)
      RD_RET: begin
        if (ras_empty_s) begin
          pc_d = RESET_VEC;
        end else begin
          pc_d = ras_top_s;
        end
      end
      RD_CALL: pc_d = jmp_tgt_i;
      RD_JMP:  pc_d = jmp_tgt_i;
      RD_BR:   pc_d = pc_q + br_off_i;
      RD_NONE: begin
        if (hs_s) begin
          pc_d = inc_s;
        end else begin
          pc_d = pc_q;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  // Control FSM with registered valid/halted flags and the PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VEC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        ST_BOOT: begin
          state_q  <= ST_RUN;
          valid_q  <= 1'b1;
          halted_q <= 1'b0;
        end
        ST_RUN: begin
          if (halt_i) begin
            state_q  <= ST_HALT;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        ST_HALT: begin
          if (!halt_i && resume_i) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b1;
            halted_q <= 1'b0;
          end else begin
            state_q  <= ST_HALT;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_BOOT;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = valid_q;
  assign halted_o      = halted_q;

`ifdef PC_SEQ_PERF_EN
  logic [15:0] redirect_cnt_q;
  logic [15:0] fetch_cnt_q;

  // Saturating counters of applied redirects and completed fetch handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= 16'h0000;
      fetch_cnt_q    <= 16'h0000;
    end else begin
      if ((rd_s != RD_NONE) && (redirect_cnt_q != PERF_MAX)) begin
        redirect_cnt_q <= redirect_cnt_q + 16'h0001;
      end else begin
        redirect_cnt_q <= redirect_cnt_q;
      end
      if (hs_s && (fetch_cnt_q != PERF_MAX)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'h0001;
      end else begin
        fetch_cnt_q <= fetch_cnt_q;
      end
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
  assign fetch_cnt_o    = fetch_cnt_q;
`endif

endmodule
